// File: rtl/da_seq_ctrl.sv
// Sequencing controller for a bit-serial distributed-arithmetic filter.
// It loads the operands, steps the sample bits MSB first, drains the carry-save pipe, then resolves the sum.
module da_seq_ctrl #(
  parameter int NMAX  = 8,
  parameter int FLUSH = 2
) (
  input  logic        clk,
  input  logic        r,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  nbits,
  input  logic [7:0]  x_in,
  input  logic [9:0]  w_in,
  input  logic [10:0] dp_sum,
  input  logic [10:0] dp_carry,
  output logic        busy,
  output logic        dp_en,
  output logic        acc_en,
  output logic [2:0]  bit_sel,
  output logic [7:0]  x_load,
  output logic [9:0]  w_load,
  output logic [11:0] result,
  output logic        result_valid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ACC     = 3'd2,
    S_FLUSH   = 3'd3,
    S_RESOLVE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [3:0] NMAX_C     = 4'(NMAX);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  n_q, n_d;
  logic [7:0]  x_q, x_d;
  logic [9:0]  w_q, w_d;
  logic [11:0] result_q, result_d;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      x_q      <= '0;
      w_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      x_q      <= x_d;
      w_q      <= w_d;
      result_q <= result_d;
    end
  end

  // ACC counts down from N-1 (it doubles as bit_sel); FLUSH counts up to its terminal value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    x_d      = x_q;
    w_d      = w_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          x_d     = x_in;
          w_d     = w_in;
          n_d     = (nbits == 4'd0 || nbits > NMAX_C) ? NMAX_C : nbits;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_ACC;
        cnt_d   = n_q - 4'd1;
      end
      S_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_RESOLVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESOLVE: begin
        state_d  = S_DONE;
        result_d = {1'b0, dp_sum} + {1'b0, dp_carry};
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Cancel wins over everything, including the RESOLVE result update.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_comb begin
    busy         = 1'b0;
    dp_en        = 1'b0;
    acc_en       = 1'b0;
    bit_sel      = 3'd0;
    result_valid = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy  = 1'b1;
        dp_en = 1'b1;
      end
      S_ACC: begin
        busy    = 1'b1;
        dp_en   = 1'b1;
        acc_en  = 1'b1;
        bit_sel = cnt_q[2:0];
      end
      S_FLUSH: begin
        busy   = 1'b1;
        dp_en  = 1'b1;
        acc_en = 1'b1;
      end
      S_RESOLVE: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign x_load = x_q;
  assign w_load = w_q;
  assign result = result_q;

endmodule

// File: tb/tb_da_seq_ctrl.sv
// Scoreboard bench for da_seq_ctrl: stimulus queues per-edge control expectations and results,
// and a negedge monitor pops and compares them as the DUT reaches each tagged edge.
module tb_da_seq_ctrl;

  localparam int F = 2;

  logic        clk = 1'b0;
  logic        r;
  logic        start, abort;
  logic [3:0]  nbits;
  logic [7:0]  x_in;
  logic [9:0]  w_in;
  logic [10:0] dp_sum, dp_carry;
  logic        busy, dp_en, acc_en, result_valid;
  logic [2:0]  bit_sel;
  logic [7:0]  x_load;
  logic [9:0]  w_load;
  logic [11:0] result;

  da_seq_ctrl #(.NMAX(8), .FLUSH(F)) dut (
    .clk(clk), .r(r), .start(start), .abort(abort), .nbits(nbits),
    .x_in(x_in), .w_in(w_in), .dp_sum(dp_sum), .dp_carry(dp_carry),
    .busy(busy), .dp_en(dp_en), .acc_en(acc_en), .bit_sel(bit_sel),
    .x_load(x_load), .w_load(w_load), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       dp;
    logic       acc;
    logic [2:0] bs;
    logic       rv;
    logic [7:0] x;
    logic [9:0] w;
  } ctl_v_t;

  typedef struct {
    int     en;
    ctl_v_t v;
  } ctl_item_t;

  typedef struct {
    int          en;
    logic [11:0] v;
  } res_item_t;

  ctl_item_t ctl_q[$];
  res_item_t res_q[$];

  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  logic [11:0] last_result = '0;
  logic [7:0]  last_x = '0;
  logic [9:0]  last_w = '0;

  always @(posedge clk) edge_cnt++;

  function automatic ctl_v_t actual_v();
    ctl_v_t a;
    a = '{busy, dp_en, acc_en, bit_sel, result_valid, x_load, w_load};
    return a;
  endfunction

  // Monitor: compares control vectors at their tagged edges and results whenever result_valid pulses.
  always @(negedge clk) begin
    ctl_item_t ci;
    res_item_t ri;
    ctl_v_t    a;
    a = actual_v();
    while (ctl_q.size() > 0 && ctl_q[0].en <= edge_cnt) begin
      ci = ctl_q.pop_front();
      checks++;
      if (ci.en != edge_cnt || a !== ci.v) begin
        failures++;
        $display("FAIL ctl edge=%0d got {busy,dp,acc,bs,rv,x,w}=%h at edge %0d want %h",
                 ci.en, a, edge_cnt, ci.v);
      end
    end
    if (result_valid) begin
      checks++;
      if (res_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected got pulse at edge %0d result=%h want no pulse", edge_cnt, result);
      end else begin
        ri = res_q.pop_front();
        if (ri.en != edge_cnt || result !== ri.v) begin
          failures++;
          $display("FAIL result got %h at edge %0d want %h at edge %0d", result, edge_cnt, ri.v, ri.en);
        end else begin
          $display("result ok %h at edge %0d", result, edge_cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h want %h", name, got, want);
    end else begin
      $display("check %s ok %h", name, got);
    end
  endtask

  task automatic push_ctl(input int e, input ctl_v_t v);
    ctl_item_t it;
    it.en = e;
    it.v  = v;
    ctl_q.push_back(it);
  endtask

  // One evaluation; abort_k/bstart_k > 0 raise abort/start so they are sampled at edge S+k.
  task automatic run(input logic [3:0] nb, input int n, input logic [7:0] x, input logic [9:0] w,
                     input logic [10:0] s, input logic [10:0] c, input int abort_k, input int bstart_k);
    int          S, L;
    logic [11:0] exp_r;
    res_item_t   ri;
    @(negedge clk);
    nbits = nb; x_in = x; w_in = w; dp_sum = s; dp_carry = c; start = 1'b1; abort = 1'b0;
    S = edge_cnt + 1;
    L = n + F + 2;
    for (int k = 0; k <= L + 1; k++) begin
      if (abort_k > 0 && k == abort_k) begin
        push_ctl(S + k, '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, x, w});
        break;
      end
      if (k == 0)            push_ctl(S + k, '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, x, w});
      else if (k <= n)       push_ctl(S + k, '{1'b1, 1'b1, 1'b1, 3'(n - k), 1'b0, x, w});
      else if (k <= n + F)   push_ctl(S + k, '{1'b1, 1'b1, 1'b1, 3'd0, 1'b0, x, w});
      else if (k == n + F + 1) push_ctl(S + k, '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, x, w});
      else if (k == L)       push_ctl(S + k, '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, x, w});
      else                   push_ctl(S + k, '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, x, w});
    end
    if (abort_k <= 0) begin
      exp_r = {1'b0, s} + {1'b0, c};
      ri.en = S + L;
      ri.v  = exp_r;
      res_q.push_back(ri);
      last_result = exp_r;
    end
    last_x = x;
    last_w = w;
    @(negedge clk);
    for (int k = 1; k <= L + 1; k++) begin
      start = (k == bstart_k);
      abort = (k == abort_k);
      @(negedge clk);
      if (k == abort_k) break;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    r = 1'b1; start = 1'b0; abort = 1'b0; nbits = '0; x_in = '0; w_in = '0;
    dp_sum = '0; dp_carry = '0;
    #3;
    check("reset_outputs", 32'(actual_v()), 32'(0));
    check("reset_result", 32'(result), 32'(0));
    repeat (2) @(negedge clk);
    r = 1'b0;

    run(4'd8,  8, 8'hFD, 10'h3FF, 11'h123, 11'h0F0, -1, -1);
    run(4'd1,  1, 8'h5A, 10'h155, 11'h001, 11'h002, -1, -1);
    run(4'd0,  8, 8'h11, 10'h022, 11'h100, 11'h200, -1, -1);
    run(4'd12, 8, 8'h33, 10'h044, 11'h0AA, 11'h055, -1, -1);
    run(4'd8,  8, 8'hC3, 10'h2AA, 11'h7FF, 11'h7FF, -1, -1);

    // Abort while bit_sel=4, with a stray start during ACC.
    run(4'd8, 8, 8'h0F, 10'h0F0, 11'h111, 11'h222, 5, 2);
    check("abort_result_kept", 32'(result), 32'(12'hFFE));

    run(4'd3, 3, 8'hA5, 10'h1C3, 11'h400, 11'h001, -1, 2);

    // start and abort together in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    push_ctl(edge_cnt + 1, '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, last_x, last_w});
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);

    // Asynchronous reset during FLUSH.
    nbits = 4'd8; x_in = 8'h77; w_in = 10'h388; dp_sum = 11'h010; dp_carry = 11'h020; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_flush", 32'({busy, dp_en, acc_en, bit_sel}), 32'(6'b111_000));
    #1 r = 1'b1;
    #1;
    check("async_reset_outputs", 32'(actual_v()), 32'(0));
    check("async_reset_result", 32'(result), 32'(0));
    @(negedge clk);
    r = 1'b0;
    last_result = '0;
    run(4'd8, 8, 8'h12, 10'h345, 11'h3FF, 11'h001, -1, -1);

    repeat (4) @(negedge clk);
    check("ctl_queue_drained", 32'(ctl_q.size()), 32'(0));
    check("res_queue_drained", 32'(res_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout reached at edge %0d", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule
